// File: rtl/memory_responder_pkg.sv
// Shared types for the CPU memory interface and the program-image loader.
package memory_responder_pkg;

    localparam int unsigned REGSIZE = 8;

    typedef enum logic [1:0] {
        MEMORY_STAY  = 2'd0,
        MEMORY_READ  = 2'd1,
        MEMORY_WRITE = 2'd2
    } MEMORY_FLAG_TYPE;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } LOADER_STATE_TYPE;

endpackage

// File: rtl/memory_responder_array.sv
// Word store: one synchronous write port and one asynchronous read port.
module memory_responder_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Responder end of the CPU memory interface: clears the store, loads a program
// image over a valid/ready port while holding the CPU in reset, then serves the CPU.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = REGSIZE,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [ADDR_WIDTH-1:0] address,
    input  MEMORY_FLAG_TYPE       rw_flag,
    input  logic [DATA_WIDTH-1:0] write_memory_value,
    output logic [DATA_WIDTH-1:0] read_memory_value,
    input  logic                  LOAD_VALID,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic                  LOAD_LAST,
    output logic                  LOAD_READY,
    output logic                  CPU_RESET,
    output logic                  RUNNING,
    output logic [ADDR_WIDTH:0]   LOADED_COUNT,
    output logic [CNT_WIDTH-1:0]  READ_COUNT,
    output logic [CNT_WIDTH-1:0]  WRITE_COUNT
);

    localparam int unsigned LC_WIDTH = ADDR_WIDTH + 1;

    LOADER_STATE_TYPE      state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
    logic [LC_WIDTH-1:0]   loaded_count_q, loaded_count_d;
    logic [CNT_WIDTH-1:0]  read_count_q, read_count_d;
    logic [CNT_WIDTH-1:0]  write_count_q, write_count_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_sel;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q        <= CLEAR;
            clear_ptr_q    <= '0;
            load_ptr_q     <= '0;
            loaded_count_q <= '0;
            read_count_q   <= '0;
            write_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            clear_ptr_q    <= clear_ptr_d;
            load_ptr_q     <= load_ptr_d;
            loaded_count_q <= loaded_count_d;
            read_count_q   <= read_count_d;
            write_count_q  <= write_count_d;
        end
    end

    // Next state, single write-port mux and counter updates.
    always_comb begin
        state_d        = state_q;
        clear_ptr_d    = clear_ptr_q;
        load_ptr_d     = load_ptr_q;
        loaded_count_d = loaded_count_q;
        read_count_d   = read_count_q;
        write_count_d  = write_count_q;
        mem_we         = 1'b0;
        mem_waddr      = clear_ptr_q;
        mem_wdata      = '0;
        rd_sel         = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
                if (clear_ptr_q == '1) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (LOAD_VALID) begin
                    mem_we         = 1'b1;
                    mem_waddr      = load_ptr_q;
                    mem_wdata      = LOAD_DATA;
                    load_ptr_d     = load_ptr_q + ADDR_WIDTH'(1);
                    loaded_count_d = loaded_count_q + LC_WIDTH'(1);
                    // Last slot ends the load even without LAST: no wrap.
                    if (LOAD_LAST || (load_ptr_q == '1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                case (rw_flag)
                    MEMORY_READ: begin
                        rd_sel = 1'b1;
                        if (read_count_q != '1) begin
                            read_count_d = read_count_q + CNT_WIDTH'(1);
                        end
                    end
                    MEMORY_WRITE: begin
                        mem_we    = 1'b1;
                        mem_waddr = address;
                        mem_wdata = write_memory_value;
                        if (write_count_q != '1) begin
                            write_count_d = write_count_q + CNT_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = CLEAR;
        endcase
    end

    memory_responder_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk   (CLOCK),
        .we    (mem_we & RESET_N),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (address),
        .rdata (mem_rdata)
    );

    assign read_memory_value = (rd_sel && RESET_N) ? mem_rdata : '0;
    assign LOAD_READY        = (state_q == LOAD);
    assign CPU_RESET         = (state_q != RUN);
    assign RUNNING           = (state_q == RUN);
    assign LOADED_COUNT      = loaded_count_q;
    assign READ_COUNT        = read_count_q;
    assign WRITE_COUNT       = write_count_q;

endmodule
